// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime baud divisor, optional parity, one or two stop bits and
// line break. A holding register in front of the shift register lets a new character be
// queued while the current one is on the line, so back-to-back frames have no idle gap.
module uart_tx_cfg #(
   parameter int unsigned P_DATA_W = 8,
   parameter int unsigned P_DIV_W  = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [P_DIV_W-1:0]  div_i,
   input  logic [P_DATA_W-1:0] data_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [1:0]          parity_mode_i,
   input  logic                stop_sel_i,
   input  logic                break_i,
   output logic                tx_o,
   output logic                busy_o,
   output logic                done_o
);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

   state_e                state_q, state_d;
   logic [P_DATA_W-1:0]   hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [P_DATA_W-1:0]   shift_q, shift_d;
   logic [P_DIV_W-1:0]    div_q, div_d;
   logic [P_DIV_W-1:0]    cnt_q, cnt_d;
   logic [3:0]            idx_q, idx_d;
   logic [1:0]            mode_q, mode_d;
   logic                  stop2_q, stop2_d;
   logic                  par_q, par_d;
   logic                  guard_q, guard_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  load;
   logic                  bit_end;
   logic                  par_new;

   // Parity of the character about to be loaded, using the mode sampled on the same edge
   always_comb begin
      par_new = 1'b0;
      unique case (parity_mode_i)
         2'b01:   par_new = ~^hold_q;
         2'b10:   par_new = ^hold_q;
         2'b11:   par_new = 1'b1;
         default: par_new = 1'b0;
      endcase
   end

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      stop2_d     = stop2_q;
      par_d       = par_q;
      guard_d     = guard_q;
      done_d      = 1'b0;
      load        = 1'b0;
      tx_d        = 1'b1;
      bit_end     = (cnt_q == div_q - 1'b1);

      unique case (state_q)
         StIdle: begin
            if (break_i) begin
               state_d = StBreak;
            end else if (hold_full_q && !guard_q) begin
               load = 1'b1;
            end
            // After a break the line must sit high one full bit time before a start bit
            if (guard_q) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == div_i - 1'b1) begin
                  guard_d = 1'b0;
                  cnt_d   = '0;
               end
            end
         end
         StStart: begin
            if (bit_end) state_d = StData;
         end
         StData: begin
            if (bit_end) begin
               if (idx_q == 4'(P_DATA_W - 1)) begin
                  state_d = (mode_q == 2'b00) ? StStop : StParity;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         StParity: begin
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            if (bit_end) begin
               if (stop2_q && (idx_q == 4'd0)) begin
                  idx_d = 4'd1;
               end else begin
                  done_d = 1'b1;
                  if (hold_full_q && !break_i) begin
                     load = 1'b1;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         StBreak: begin
            if (!break_i) begin
               state_d = StIdle;
               guard_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Move holding register into the shift register and latch the frame configuration
      if (load) begin
         state_d     = StStart;
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         div_d       = div_i;
         mode_d      = parity_mode_i;
         stop2_d     = stop_sel_i;
         par_d       = par_new;
      end

      // Accept only when empty; a load and an accept can never share an edge
      if (valid_i && !hold_full_q) begin
         hold_d      = data_i;
         hold_full_d = 1'b1;
      end

      // Bit timing restarts on every state change
      if (state_d != state_q) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (state_q != StIdle && state_q != StBreak) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         StBreak:  tx_d = 1'b0;
         default:  tx_d = 1'b1;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         mode_q      <= 2'b00;
         stop2_q     <= 1'b0;
         par_q       <= 1'b0;
         guard_q     <= 1'b0;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         stop2_q     <= stop2_d;
         par_q       <= par_d;
         guard_q     <= guard_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
      end
   end

   assign ready_o = ~hold_full_q;
   assign tx_o    = tx_q;
   assign busy_o  = (state_q != StIdle);
   assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit instance for most scenarios, 7-bit instance for
// the narrow-character frame.
module tb_uart_tx_cfg;

   logic        clk;
   logic        rst_n;
   logic [15:0] div;
   logic [7:0]  data;
   logic        valid;
   logic        ready;
   logic [1:0]  pmode;
   logic        stop_sel;
   logic        brk;
   logic        tx;
   logic        busy;
   logic        done;

   logic [15:0] div_b;
   logic [6:0]  data_b;
   logic        valid_b;
   logic        ready_b;
   logic [1:0]  pmode_b;
   logic        stop_b;
   logic        brk_b;
   logic        tx_b;
   logic        busy_b;
   logic        done_b;

   int errors;
   int checks;

   uart_tx_cfg #(.P_DATA_W(8), .P_DIV_W(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .div_i(div), .data_i(data), .valid_i(valid),
      .ready_o(ready), .parity_mode_i(pmode), .stop_sel_i(stop_sel), .break_i(brk),
      .tx_o(tx), .busy_o(busy), .done_o(done)
   );

   uart_tx_cfg #(.P_DATA_W(7), .P_DIV_W(16)) dut_w7 (
      .clk_i(clk), .rst_n_i(rst_n), .div_i(div_b), .data_i(data_b), .valid_i(valid_b),
      .ready_o(ready_b), .parity_mode_i(pmode_b), .stop_sel_i(stop_b), .break_i(brk_b),
      .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Push one character; returns on the negedge before the START edge
   task automatic send_a(input logic [7:0] d);
      @(negedge clk);
      data  = d;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Sample a frame bit by bit; 'pre' start-bit samples were already taken by the caller
   task automatic run_frame(input int div_n, input int nbits, input int pre,
                            output logic [15:0] bits, output int unstable, output int dones);
      int first;
      bits = '0;
      unstable = 0;
      dones = 0;
      for (int b = 0; b < nbits; b++) begin
         first = (b == 0) ? pre : 0;
         for (int c = 0; c < div_n; c++) begin
            if (c >= first) begin
               @(negedge clk);
               if (c == first) bits[b] = tx;
               else if (tx !== bits[b]) unstable++;
               if (done === 1'b1) dones++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (tx_b !== 1'b1)  begin errors++; $display("FAIL reset_tx_w7: got %b want 1", tx_b); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_frame();
      logic [15:0] bits;
      int unstable, dones;
      div = 16'd4; pmode = 2'b00; stop_sel = 1'b0;
      send_a(8'hA5);
      run_frame(4, 10, 0, bits, unstable, dones);
      checks++; if (bits[9:0] !== 10'h34A) begin errors++; $display("FAIL basic_bits: got %h want 34a", bits[9:0]); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL basic_bit_width: got %0d glitches want 0", unstable); end
      checks++; if (dones !== 0) begin errors++; $display("FAIL basic_early_done: got %0d want 0", dones); end
      @(negedge clk);
      checks++; if (done !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL basic_done: got done=%b tx=%b want 1 1", done, tx); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_parity();
      logic [15:0] bits;
      logic [1:0]  modes [3];
      logic [10:0] want [3];
      int unstable, dones;
      modes[0] = 2'b10; want[0] = 11'h54A;   // even: parity 0
      modes[1] = 2'b01; want[1] = 11'h74A;   // odd: parity 1
      modes[2] = 2'b11; want[2] = 11'h74A;   // mark: parity 1
      for (int m = 0; m < 3; m++) begin
         div = 16'd4; pmode = modes[m]; stop_sel = 1'b0;
         send_a(8'hA5);
         run_frame(4, 11, 0, bits, unstable, dones);
         checks++;
         if (bits[10:0] !== want[m] || unstable !== 0) begin
            errors++;
            $display("FAIL parity_mode%0d: got %h glitches=%0d want %h", m, bits[10:0], unstable, want[m]);
         end
         @(negedge clk);
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL parity_done%0d: got %b want 1", m, done); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] f1, f2;
      logic exp_tx, exp_done;
      int bad_tx, bad_done, bad_busy;
      f1 = 11'h602;
      f2 = 11'h700;
      div = 16'd4; pmode = 2'b00; stop_sel = 1'b1;
      @(negedge clk);
      data = 8'h01; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data = 8'h80;   // held high while full: must only be taken once ready returns
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", ready); end
      bad_tx = 0; bad_done = 0;
      for (int c = 0; c < 88; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_move: got %b want 1", ready); end
         end
         if (c == 1) valid = 1'b0;
         exp_tx   = (c < 44) ? f1[c / 4] : f2[(c - 44) / 4];
         exp_done = (c == 44);
         if (tx !== exp_tx) bad_tx++;
         if (done !== exp_done) bad_done++;
      end
      checks++; if (bad_tx !== 0) begin errors++; $display("FAIL b2b_tx: got %0d wrong cycles want 0", bad_tx); end
      checks++; if (bad_done !== 0) begin errors++; $display("FAIL b2b_done: got %0d wrong cycles want 0", bad_done); end
      @(negedge clk);
      checks++; if (done !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL b2b_end: got done=%b tx=%b want 1 1", done, tx); end
      bad_busy = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx !== 1'b1) bad_busy++;
      end
      checks++; if (bad_busy !== 0) begin errors++; $display("FAIL b2b_no_dup: got %0d busy cycles want 0", bad_busy); end
   endtask

   task automatic test_reset_mid_frame();
      int bad, dones;
      div = 16'd4; pmode = 2'b00; stop_sel = 1'b0;
      send_a(8'hA5);
      dones = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (c == 2) begin data = 8'h55; valid = 1'b1; end
         if (c == 3) valid = 1'b0;
         if (done === 1'b1) dones++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         if (done === 1'b1) dones++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_discard: got %0d active cycles want 0", bad); end
      checks++; if (dones !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d pulses want 0", dones); end
   endtask

   task automatic test_break();
      logic [15:0] bits;
      int unstable, dones, bad_low, high;
      logic seen_low;
      div = 16'd4; pmode = 2'b00; stop_sel = 1'b0;
      @(negedge clk);
      brk = 1'b1; data = 8'h55; valid = 1'b1;
      bad_low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) valid = 1'b0;
         if (tx !== 1'b0) bad_low++;
         if (i == 19) brk = 1'b0;
      end
      checks++; if (bad_low !== 0) begin errors++; $display("FAIL break_low: got %0d high cycles want 0", bad_low); end
      high = 0;
      seen_low = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (tx === 1'b1) high++;
         else begin
            seen_low = 1'b1;
            break;
         end
      end
      checks++; if (!seen_low) begin errors++; $display("FAIL break_queued_start: got no start bit want one within 50 cycles"); end
      checks++; if (high < 4) begin errors++; $display("FAIL break_recover: got %0d high cycles want >=4", high); end
      if (seen_low) begin
         run_frame(4, 10, 1, bits, unstable, dones);
         checks++;
         if (bits[9:0] !== 10'h2AA || unstable !== 0) begin
            errors++;
            $display("FAIL break_frame: got %h glitches=%0d want 2aa", bits[9:0], unstable);
         end
         @(negedge clk);
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL break_frame_done: got %b want 1", done); end
      end
   endtask

   task automatic test_width7();
      logic [9:0] want;
      int bad, dones;
      want = 10'h382;
      div_b = 16'd3; pmode_b = 2'b01; stop_b = 1'b0;
      @(negedge clk);
      data_b = 7'h41; valid_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_b = 1'b0;
      bad = 0; dones = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 0) div_b = 16'd5;   // frame must keep the divisor latched at start
         if (tx_b !== want[c / 3]) bad++;
         if (done_b === 1'b1) dones++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL w7_frame: got %0d wrong cycles want 0", bad); end
      checks++; if (dones !== 0) begin errors++; $display("FAIL w7_early_done: got %0d want 0", dones); end
      @(negedge clk);
      checks++; if (done_b !== 1'b1 || tx_b !== 1'b1) begin errors++; $display("FAIL w7_done: got done=%b tx=%b want 1 1", done_b, tx_b); end
      @(negedge clk);
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL w7_idle: got %b want 0", busy_b); end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      div = 16'd4; data = '0; valid = 1'b0; pmode = 2'b00; stop_sel = 1'b0; brk = 1'b0;
      div_b = 16'd3; data_b = '0; valid_b = 1'b0; pmode_b = 2'b00; stop_b = 1'b0; brk_b = 1'b0;
      test_reset();
      test_basic_frame();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      test_break();
      test_width7();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
